// File: rtl/bitpipe_sched.sv
// Round-robin scheduler sharing one bit-serial delay-line pipe between NREQ requesters.
// Optional parity bit per word when BITPIPE_SCHED_PARITY_EN is defined.
module bitpipe_sched #(
    parameter int NREQ = 4,
    parameter int WW   = 8,
    parameter int LN   = 8,
    parameter int IDW  = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*WW-1:0] i_data,
    output logic [NREQ-1:0]    o_grant,
    output logic               o_pipe_ce,
    output logic               o_pipe_in,
    input  logic               i_pipe_bit,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [IDW-1:0]     o_id,
    output logic [WW-1:0]      o_data,
    output logic               o_perr
);

`ifdef BITPIPE_SCHED_PARITY_EN
    localparam int NB = WW + 1;
`else
    localparam int NB = WW;
`endif
    localparam int CW = $clog2(NB + LN + 1);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CNT_NB   = CW'(NB);
    localparam logic [CW-1:0] CNT_LN   = CW'(LN);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB + LN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  last_reg, last_next;
    logic [IDW-1:0]  id_reg, id_next;
    logic [NB-1:0]   tx_reg, tx_next;
    logic [NB-1:0]   rx_reg, rx_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            quiet_reg, quiet_next;

    logic [WW-1:0]   words [NREQ];
    logic [SW-1:0]   pick_sel;
    logic [SW-1:0]   rr_sel;
    logic            pick_found;
    logic            grant_en;
    logic [WW-1:0]   pick_word;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign words[gi]   = i_data[gi*WW +: WW];
            assign o_grant[gi] = grant_en && (pick_sel == SW'(gi));
        end
    endgenerate

    // Descending scan so the nearest requester after last_reg wins.
    always_comb begin
        pick_found = 1'b0;
        pick_sel   = '0;
        rr_sel     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            rr_sel = SW'((int'(last_reg) + i) % NREQ);
            if (i_req[rr_sel]) begin
                pick_found = 1'b1;
                pick_sel   = rr_sel;
            end
        end
    end

    // One quiet IDLE cycle follows every accepted result before the next grant.
    assign grant_en  = (state_reg == IDLE) && !quiet_reg && pick_found && !i_reset;
    assign pick_word = words[pick_sel];

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        id_next    = id_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        cnt_next   = cnt_reg;
        quiet_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_en) begin
                    last_next  = IDW'(pick_sel);
                    id_next    = IDW'(pick_sel);
`ifdef BITPIPE_SCHED_PARITY_EN
                    tx_next    = {^pick_word, pick_word};
`else
                    tx_next    = pick_word;
`endif
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                tx_next = tx_reg >> 1;
                if (cnt_reg >= CNT_LN) begin
                    rx_next = {i_pipe_bit, rx_reg[NB-1:1]};
                end
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                    quiet_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= IDLE;
            last_reg  <= IDW'(NREQ - 1);
            id_reg    <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            cnt_reg   <= '0;
            quiet_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            id_reg    <= id_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            cnt_reg   <= cnt_next;
            quiet_reg <= quiet_next;
        end
    end

    assign o_pipe_ce = (state_reg == BUSY);
    assign o_pipe_in = (state_reg == BUSY) && (cnt_reg < CNT_NB) ? tx_reg[0] : 1'b0;
    assign o_valid   = (state_reg == DONE);
    assign o_id      = id_reg;
    assign o_data    = rx_reg[WW-1:0];
`ifdef BITPIPE_SCHED_PARITY_EN
    assign o_perr    = (state_reg == DONE) && (^rx_reg);
`else
    assign o_perr    = 1'b0;
`endif

endmodule
